// File: rtl/rx_intf_pkg.sv
// ---------------------------------------------------------------------------
// rx_intf_pkg
// Shared definitions for the rx byte-to-word packer slice:
//   - packer FSM state encoding
//   - byte-lane geometry of the 64-bit output word
//   - layout of the status byte written into the final PSDU byte lane
// No ports (package).
// ---------------------------------------------------------------------------
package rx_intf_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int LANE_W         = 3;

  // Status byte layout: {fcs_flag, rx_sn[6:0]}
  localparam int INS_FCS_BIT = 7;
  localparam int INS_SN_MSB  = 6;
  localparam int INS_SN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PACK      = 2'd1,
    WAIT_FCS  = 2'd2,
    EMIT_LAST = 2'd3
  } state_e;

  // Builds the byte that replaces the last PSDU byte of a packet.
  function automatic logic [7:0] insert_byte(input logic fcs, input logic [6:0] sn);
    logic [7:0] b;
    b = '0;
    b[INS_FCS_BIT] = fcs;
    b[INS_SN_MSB:INS_SN_LSB] = sn;
    return b;
  endfunction

endpackage

// File: rtl/rx_intf_byte_to_word_packer_if.sv
// ---------------------------------------------------------------------------
// rx_intf_byte_to_word_packer_if
// Bundles the decoder-side byte stream and the DMA-side word stream of the
// packer.
//   master : the side that feeds packets (decoder / testbench)
//   slave  : the packer itself
// Signals: pkt_start, pkt_len[15:0], ht_unsupport, byte_in[7:0],
//          byte_in_strobe, fcs_in_strobe, fcs_ok, rx_pkt_sn_plus_one  (to packer)
//          word_out[WORD_WIDTH-1:0], word_out_strobe, rx_sn[SN_WIDTH-1:0],
//          monitor_word_count[12:0]                                   (from packer)
// ---------------------------------------------------------------------------
interface rx_intf_byte_to_word_packer_if #(
  parameter int WORD_WIDTH = 64,
  parameter int SN_WIDTH   = 7
);
  logic                  pkt_start;
  logic [15:0]           pkt_len;
  logic                  ht_unsupport;
  logic [7:0]            byte_in;
  logic                  byte_in_strobe;
  logic                  fcs_in_strobe;
  logic                  fcs_ok;
  logic                  rx_pkt_sn_plus_one;
  logic [WORD_WIDTH-1:0] word_out;
  logic                  word_out_strobe;
  logic [SN_WIDTH-1:0]   rx_sn;
  logic [12:0]           monitor_word_count;

  modport master (
    output pkt_start, pkt_len, ht_unsupport, byte_in, byte_in_strobe,
           fcs_in_strobe, fcs_ok, rx_pkt_sn_plus_one,
    input  word_out, word_out_strobe, rx_sn, monitor_word_count
  );

  modport slave (
    input  pkt_start, pkt_len, ht_unsupport, byte_in, byte_in_strobe,
           fcs_in_strobe, fcs_ok, rx_pkt_sn_plus_one,
    output word_out, word_out_strobe, rx_sn, monitor_word_count
  );
endinterface

// File: rtl/rx_intf_lane_writer.sv
// ---------------------------------------------------------------------------
// rx_intf_lane_writer
// 64-bit byte-lane buffer for the packer.
//   clk, rstn    : clock, synchronous active-low reset
//   clear_i      : empty the buffer (wins over a write in the same cycle)
//   wr_en_i      : write wr_byte_i into lane wr_lane_i
//   ovr_lane_i   : lane replaced by ovr_byte_i in the last_o view
//   merged_o     : buffer contents including this cycle's write
//   last_o       : buffer contents with the override lane replaced
// ---------------------------------------------------------------------------
module rx_intf_lane_writer
  import rx_intf_pkg::*;
#(
  parameter int WORD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [LANE_W-1:0]     wr_lane_i,
  input  logic [7:0]            wr_byte_i,
  input  logic [LANE_W-1:0]     ovr_lane_i,
  input  logic [7:0]            ovr_byte_i,
  output logic [WORD_WIDTH-1:0] merged_o,
  output logic [WORD_WIDTH-1:0] last_o
);

  logic [WORD_WIDTH-1:0] buf_q, buf_d;

  // The merged view lets a full word be emitted in the same cycle its
  // lane 7 byte arrives, while the buffer itself is cleared.
  always_comb begin
    merged_o = buf_q;
    if (wr_en_i) merged_o[8*wr_lane_i +: 8] = wr_byte_i;
  end

  always_comb begin
    last_o = buf_q;
    last_o[8*ovr_lane_i +: 8] = ovr_byte_i;
  end

  always_comb begin
    buf_d = clear_i ? '0 : merged_o;
  end

  always_ff @(posedge clk) begin
    if (!rstn) buf_q <= '0;
    else       buf_q <= buf_d;
  end

endmodule

// File: rtl/rx_intf_byte_to_word_packer.sv
// ---------------------------------------------------------------------------
// rx_intf_byte_to_word_packer
// Packs the decoded PSDU byte stream into 64-bit little-endian words for the
// rx DMA path. The final PSDU byte is overwritten with {fcs_flag, rx_sn};
// exactly ceil(pkt_len/8) words are emitted per accepted packet.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : rx_intf_byte_to_word_packer_if.slave (byte stream in,
//               word stream / rx_sn / monitor_word_count out)
// Optional feature macro RX_INTF_BYTE_TO_WORD_SN_EN:
//   defined   -> rx_sn counter advanced by rx_pkt_sn_plus_one
//   undefined -> rx_sn tied to 0, rx_pkt_sn_plus_one unused
// ---------------------------------------------------------------------------
module rx_intf_byte_to_word_packer
  import rx_intf_pkg::*;
#(
  parameter int WORD_WIDTH   = 64,
  parameter int SN_WIDTH     = 7,
  parameter int FCS_WAIT_TOP = 4095
) (
  input logic                         clk,
  input logic                         rstn,
  rx_intf_byte_to_word_packer_if.slave bus
);

  localparam int WAIT_W = $clog2(FCS_WAIT_TOP + 1);

  state_e                state_q, state_d;
  logic [15:0]           byte_cnt_q, byte_cnt_d;
  logic [15:0]           pkt_len_q, pkt_len_d;
  logic                  fcs_flag_q, fcs_flag_d;
  logic                  fcs_seen_q, fcs_seen_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  strobe_q, strobe_d;
  logic [12:0]           word_cnt_q, word_cnt_d;
  logic [SN_WIDTH-1:0]   sn_q;

  logic                  start_ok;
  logic                  buf_clear, buf_wr_en;
  logic [LANE_W-1:0]     last_lane;
  logic [15:0]           last_idx;
  logic [WORD_WIDTH-1:0] buf_merged, buf_last;

  assign start_ok  = bus.pkt_start && !bus.ht_unsupport && (bus.pkt_len != 16'd0);
  assign last_idx  = pkt_len_q - 16'd1;
  assign last_lane = last_idx[LANE_W-1:0];

`ifdef RX_INTF_BYTE_TO_WORD_SN_EN
  // Sequence number runs in every state; EMIT_LAST reads the registered
  // value, so a coincident pulse is seen only by the next packet.
  always_ff @(posedge clk) begin
    if (!rstn)                       sn_q <= '0;
    else if (bus.rx_pkt_sn_plus_one) sn_q <= sn_q + 1'b1;
  end
`else
  logic unused_sn_pulse;
  assign unused_sn_pulse = bus.rx_pkt_sn_plus_one;
  assign sn_q = '0;
`endif

  rx_intf_lane_writer #(.WORD_WIDTH(WORD_WIDTH)) u_lane_writer (
    .clk        (clk),
    .rstn       (rstn),
    .clear_i    (buf_clear),
    .wr_en_i    (buf_wr_en),
    .wr_lane_i  (byte_cnt_q[LANE_W-1:0]),
    .wr_byte_i  (bus.byte_in),
    .ovr_lane_i (last_lane),
    .ovr_byte_i (insert_byte(fcs_flag_q, 7'(sn_q))),
    .merged_o   (buf_merged),
    .last_o     (buf_last)
  );

  // Next-state and output logic. A pkt_start is applied last so it can
  // abort a packet in flight; only EMIT_LAST still delivers its word.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pkt_len_d  = pkt_len_q;
    fcs_flag_d = fcs_flag_q;
    fcs_seen_d = fcs_seen_q;
    wait_cnt_d = wait_cnt_q;
    word_d     = word_q;
    strobe_d   = 1'b0;
    word_cnt_d = word_cnt_q;
    buf_clear  = 1'b0;
    buf_wr_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      PACK: begin
        if (bus.fcs_in_strobe) begin
          fcs_flag_d = bus.fcs_ok;
          fcs_seen_d = 1'b1;
        end
        if (bus.byte_in_strobe) begin
          buf_wr_en  = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == last_idx) begin
            // Last byte stays in the buffer until the FCS verdict is known.
            state_d    = bus.fcs_in_strobe ? EMIT_LAST : WAIT_FCS;
            wait_cnt_d = '0;
          end else if (byte_cnt_q[LANE_W-1:0] == 3'd7) begin
            word_d     = buf_merged;
            strobe_d   = 1'b1;
            buf_clear  = 1'b1;
            word_cnt_d = word_cnt_q + 13'd1;
          end
        end
      end
      WAIT_FCS: begin
        if (fcs_seen_q) begin
          state_d = EMIT_LAST;
        end else if (bus.fcs_in_strobe) begin
          fcs_flag_d = bus.fcs_ok;
          fcs_seen_d = 1'b1;
          state_d    = EMIT_LAST;
        end else if (wait_cnt_q == WAIT_W'(FCS_WAIT_TOP - 1)) begin
          fcs_flag_d = 1'b0;
          state_d    = EMIT_LAST;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      EMIT_LAST: begin
        word_d     = buf_last;
        strobe_d   = 1'b1;
        word_cnt_d = word_cnt_q + 13'd1;
        buf_clear  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.pkt_start) begin
      if (state_q != EMIT_LAST) begin
        strobe_d   = 1'b0;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
      end
      buf_clear  = 1'b1;
      byte_cnt_d = '0;
      fcs_flag_d = 1'b0;
      fcs_seen_d = 1'b0;
      wait_cnt_d = '0;
      if (start_ok) begin
        pkt_len_d  = bus.pkt_len;
        word_cnt_d = '0;
        state_d    = PACK;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      pkt_len_q  <= '0;
      fcs_flag_q <= 1'b0;
      fcs_seen_q <= 1'b0;
      wait_cnt_q <= '0;
      word_q     <= '0;
      strobe_q   <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_len_q  <= pkt_len_d;
      fcs_flag_q <= fcs_flag_d;
      fcs_seen_q <= fcs_seen_d;
      wait_cnt_q <= wait_cnt_d;
      word_q     <= word_d;
      strobe_q   <= strobe_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.word_out           = word_q;
  assign bus.word_out_strobe    = strobe_q;
  assign bus.rx_sn              = sn_q;
  assign bus.monitor_word_count = word_cnt_q;

endmodule
